// File: rtl/run_det_pkg.sv
// run_det_pkg: shared state encoding, mode constants and run qualification for run_parity_detector
package run_det_pkg;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ODD = 2'd1, S_EVEN = 2'd2} state_t;
    localparam logic [1:0] MODE_EVEN = 2'b00;
    localparam logic [1:0] MODE_ODD  = 2'b01;
    localparam logic [1:0] MODE_MIN  = 2'b10;
    localparam logic [1:0] MODE_ANY  = 2'b11;
    function automatic logic qualify(input state_t s, input logic ge_min, input logic [1:0] mode);
        return mode == MODE_EVEN ? s == S_EVEN :
               mode == MODE_ODD  ? s == S_ODD  :
               mode == MODE_MIN  ? ge_min      : 1'b1;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; clear then inc in one edge yields 1, sat_hit flags an increment at all-ones
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat_hit
);
    logic [W-1:0] count_q, count_d, base;
    always_comb begin
        base    = clear ? '0 : count_q;
        count_d = (inc && base != '1) ? base + W'(1) : base;
        sat_hit = inc && base == '1;
    end
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end
    assign count = count_q;
endmodule

// File: rtl/run_parity_detector.sv
// run_parity_detector: tracks runs of a target bit and pulses y when a terminated run matches the selected mode
module run_parity_detector
    import run_det_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int MIN_RUN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             target,
    input  logic [1:0]       mode,
    output logic             y,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] last_len,
    output logic             ovf
);
    localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_RUN);
    if (MIN_RUN < 1 || MIN_RUN > (2 ** CNT_W) - 1) begin : g_bad_min_run
        $error("run_parity_detector: MIN_RUN out of range for CNT_W");
    end
    state_t           state_q, state_d, cur;
    logic             tgt_q, tgt_d, y_q, y_d, ovf_q, ovf_d, hit, clr, inc, sat_hit;
    logic [CNT_W-1:0] last_len_q, last_len_d;
    sat_counter #(.W(CNT_W)) u_run_cnt (
        .clk(clk), .reset(reset), .clear(clr), .inc(inc), .count(run_len), .sat_hit(sat_hit)
    );
    // A target change aborts an open run; the same edge's bit is then judged from idle.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        last_len_d = last_len_q;
        y_d        = 1'b0;
        clr        = 1'b0;
        inc        = 1'b0;
        hit        = x == target;
        cur        = (state_q != S_IDLE && target != tgt_q) ? S_IDLE : state_q;
        if (en) begin
            tgt_d = target;
            if (cur == S_ODD || cur == S_EVEN) begin
                if (hit) begin
                    state_d = cur == S_ODD ? S_EVEN : S_ODD;
                    inc     = 1'b1;
                end else begin
                    state_d    = S_IDLE;
                    clr        = 1'b1;
                    last_len_d = run_len;
                    y_d        = qualify(cur, run_len >= MIN_W, mode);
                end
            end else begin
                state_d = hit ? S_ODD : S_IDLE;
                clr     = 1'b1;
                inc     = hit;
            end
        end
    end
    always_comb ovf_d = ovf_q | (en & sat_hit);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tgt_q      <= target;
            last_len_q <= '0;
            y_q        <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            last_len_q <= last_len_d;
            y_q        <= y_d;
            ovf_q      <= ovf_d;
        end
    end
    assign y        = y_q;
    assign last_len = last_len_q;
    assign ovf      = ovf_q;
endmodule
